// File: rtl/object_mover_pkg.sv
// rtl/object_mover_pkg.sv - shared constants, edge indices and FSM states for the object mover
package object_mover_pkg;

  localparam int FRAC_BITS              = 6;
  localparam int FIXED_POINT_MULTIPLIER = 64;

  // Bit positions inside HitEdgeCode, also used by the hit-detection stage
  localparam int EDGE_LEFT   = 0;
  localparam int EDGE_TOP    = 1;
  localparam int EDGE_RIGHT  = 2;
  localparam int EDGE_BOTTOM = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLIDE,
    S_MOVE,
    S_CLAMP
  } mover_state_e;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

endpackage

// File: rtl/object_mover_if.sv
// rtl/object_mover_if.sv - frame/event inputs and position outputs of the object mover
interface object_mover_if;

  logic        startOfFrame;
  logic        jumpKey;
  logic        collision;
  logic [3:0]  HitEdgeCode;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;

  modport master (
    output startOfFrame, jumpKey, collision, HitEdgeCode,
    input  topLeftX, topLeftY
  );

  modport slave (
    input  startOfFrame, jumpKey, collision, HitEdgeCode,
    output topLeftX, topLeftY
  );

endinterface

// File: rtl/object_mover.sv
// rtl/object_mover.sv - per-frame fixed-point position integrator with gravity, bounce, jump and clamp
import object_mover_pkg::*;

module object_mover #(
  parameter int INITIAL_X       = 280,
  parameter int INITIAL_Y       = 185,
  parameter int INITIAL_X_SPEED = 40,
  parameter int INITIAL_Y_SPEED = 20,
  parameter int Y_ACCEL         = 1,
  parameter int MAX_Y_SPEED     = 230,
  parameter int JUMP_SPEED      = -200,
  parameter int OBJECT_WIDTH_X  = 32,
  parameter int OBJECT_HEIGHT_Y = 32,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480
) (
  input  logic          clk,
  input  logic          resetN,
  object_mover_if.slave bus
);

  localparam int MAX_POS_X = (SCREEN_W - OBJECT_WIDTH_X) * FIXED_POINT_MULTIPLIER;
  localparam int MAX_POS_Y = (SCREEN_H - OBJECT_HEIGHT_Y) * FIXED_POINT_MULTIPLIER;

  mover_state_e state, state_n;
  int           pos_x, pos_y, x_speed, y_speed;
  int           pos_x_n, pos_y_n, x_speed_n, y_speed_n;
  logic [3:0]   hit_flags, hit_flags_n, new_hits;
  logic         jump_pending, jump_pending_n, jump_prev, jump_edge;
  logic [10:0]  top_left_x, top_left_y, top_left_x_n, top_left_y_n;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n        = state;
    pos_x_n        = pos_x;
    pos_y_n        = pos_y;
    x_speed_n      = x_speed;
    y_speed_n      = y_speed;
    top_left_x_n   = top_left_x;
    top_left_y_n   = top_left_y;
    new_hits       = bus.collision ? bus.HitEdgeCode : 4'b0000;
    jump_edge      = bus.jumpKey & ~jump_prev;
    hit_flags_n    = hit_flags | new_hits;
    jump_pending_n = jump_pending | jump_edge;

    case (state)
      S_IDLE: begin
        if (bus.startOfFrame) state_n = S_COLLIDE;
      end
      S_COLLIDE: begin
        // Events arriving in this cycle survive the clear and act next frame
        hit_flags_n    = new_hits;
        jump_pending_n = jump_edge;
        if ((hit_flags[EDGE_LEFT] && x_speed < 0) || (hit_flags[EDGE_RIGHT] && x_speed > 0))
          x_speed_n = -x_speed;
        if ((hit_flags[EDGE_TOP] && y_speed < 0) || (hit_flags[EDGE_BOTTOM] && y_speed > 0))
          y_speed_n = -y_speed;
        if (jump_pending) y_speed_n = JUMP_SPEED;
        state_n = S_MOVE;
      end
      S_MOVE: begin
        pos_x_n = pos_x + x_speed;
        pos_y_n = pos_y + y_speed;
        if (y_speed < MAX_Y_SPEED) y_speed_n = y_speed + Y_ACCEL;
        state_n = S_CLAMP;
      end
      S_CLAMP: begin
        if (pos_x < 0) begin
          pos_x_n   = 0;
          x_speed_n = iabs(x_speed);
        end else if (pos_x > MAX_POS_X) begin
          pos_x_n   = MAX_POS_X;
          x_speed_n = -iabs(x_speed);
        end
        if (pos_y < 0) begin
          pos_y_n   = 0;
          y_speed_n = iabs(y_speed);
        end else if (pos_y > MAX_POS_Y) begin
          pos_y_n   = MAX_POS_Y;
          y_speed_n = -iabs(y_speed);
        end
        top_left_x_n = 11'(pos_x_n >>> FRAC_BITS);
        top_left_y_n = 11'(pos_y_n >>> FRAC_BITS);
        state_n      = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pos_x        <= INITIAL_X * FIXED_POINT_MULTIPLIER;
      pos_y        <= INITIAL_Y * FIXED_POINT_MULTIPLIER;
      x_speed      <= INITIAL_X_SPEED;
      y_speed      <= INITIAL_Y_SPEED;
      hit_flags    <= 4'b0000;
      jump_pending <= 1'b0;
      jump_prev    <= 1'b0;
      top_left_x   <= 11'(INITIAL_X);
      top_left_y   <= 11'(INITIAL_Y);
    end else begin
      pos_x        <= pos_x_n;
      pos_y        <= pos_y_n;
      x_speed      <= x_speed_n;
      y_speed      <= y_speed_n;
      hit_flags    <= hit_flags_n;
      jump_pending <= jump_pending_n;
      jump_prev    <= bus.jumpKey;
      top_left_x   <= top_left_x_n;
      top_left_y   <= top_left_y_n;
    end
  end

  assign bus.topLeftX = top_left_x;
  assign bus.topLeftY = top_left_y;

endmodule

// File: tb/tb_object_mover.sv
// tb/tb_object_mover.sv - directed and randomized checks of object_mover against a frame-level model
module tb_object_mover;
  import object_mover_pkg::*;

  logic       clk = 1'b0;
  logic       resetN;
  logic       sof, jk, col;
  logic [3:0] code;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  object_mover_if if_a ();
  object_mover_if if_b ();

  assign if_a.startOfFrame = sof;
  assign if_a.jumpKey      = jk;
  assign if_a.collision    = col;
  assign if_a.HitEdgeCode  = code;
  assign if_b.startOfFrame = sof;
  assign if_b.jumpKey      = jk;
  assign if_b.collision    = col;
  assign if_b.HitEdgeCode  = code;

  object_mover dut_a (.clk(clk), .resetN(resetN), .bus(if_a));
  object_mover #(.INITIAL_X(600)) dut_b (.clk(clk), .resetN(resetN), .bus(if_b));

  // Frame-level reference: one entry per DUT instance
  int         init_x [2];
  int         m_px [2], m_py [2], m_xs [2], m_ys [2];
  logic [3:0] m_hits [2];
  bit         m_jump [2];

  function automatic void m_reset();
    for (int i = 0; i < 2; i++) begin
      m_px[i] = init_x[i] * 64;  m_py[i] = 185 * 64;
      m_xs[i] = 40;              m_ys[i] = 20;
      m_hits[i] = 4'b0;          m_jump[i] = 1'b0;
    end
  endfunction

  function automatic void m_frame();
    for (int i = 0; i < 2; i++) begin
      if ((m_hits[i][0] && m_xs[i] < 0) || (m_hits[i][2] && m_xs[i] > 0)) m_xs[i] = -m_xs[i];
      if ((m_hits[i][1] && m_ys[i] < 0) || (m_hits[i][3] && m_ys[i] > 0)) m_ys[i] = -m_ys[i];
      if (m_jump[i]) m_ys[i] = -200;
      m_hits[i] = 4'b0;
      m_jump[i] = 1'b0;
      m_px[i] += m_xs[i];
      m_py[i] += m_ys[i];
      if (m_ys[i] < 230) m_ys[i] += 1;
      if (m_px[i] < 0) begin m_px[i] = 0; m_xs[i] = (m_xs[i] < 0) ? -m_xs[i] : m_xs[i]; end
      if (m_px[i] > 608 * 64) begin m_px[i] = 608 * 64; m_xs[i] = (m_xs[i] > 0) ? -m_xs[i] : m_xs[i]; end
      if (m_py[i] < 0) begin m_py[i] = 0; m_ys[i] = (m_ys[i] < 0) ? -m_ys[i] : m_ys[i]; end
      if (m_py[i] > 448 * 64) begin m_py[i] = 448 * 64; m_ys[i] = (m_ys[i] > 0) ? -m_ys[i] : m_ys[i]; end
    end
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " a.x"},  int'(if_a.topLeftX), m_px[0] / 64);
    check({tag, " a.y"},  int'(if_a.topLeftY), m_py[0] / 64);
    check({tag, " b.x"},  int'(if_b.topLeftX), m_px[1] / 64);
    check({tag, " b.y"},  int'(if_b.topLeftY), m_py[1] / 64);
    check({tag, " a.xs"}, dut_a.x_speed, m_xs[0]);
    check({tag, " a.ys"}, dut_a.y_speed, m_ys[0]);
    check({tag, " b.xs"}, dut_b.x_speed, m_xs[1]);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_frame();
    sof = 1'b1; tick(); sof = 1'b0;
    repeat (8) tick();
    m_frame();
  endtask

  task automatic pulse_hit(input logic [3:0] c);
    col = 1'b1; code = c; tick(); col = 1'b0; code = 4'b0;
    for (int i = 0; i < 2; i++) m_hits[i] |= c;
  endtask

  task automatic press_jump();
    jk = 1'b1; tick();
    for (int i = 0; i < 2; i++) m_jump[i] = 1'b1;
  endtask

  initial begin
    init_x[0] = 280;
    init_x[1] = 600;
    resetN = 1'b0; sof = 1'b0; jk = 1'b0; col = 1'b0; code = 4'b0;
    m_reset();
    repeat (3) tick();
    check("reset a.x", int'(if_a.topLeftX), 280);
    check("reset a.y", int'(if_a.topLeftY), 185);
    check("reset b.x", int'(if_b.topLeftX), 600);
    check("reset state", int'(dut_a.state), int'(S_IDLE));
    resetN = 1'b1; tick();

    run_frame();
    check("f1 a.posx", dut_a.pos_x, 17960);
    check("f1 a.posy", dut_a.pos_y, 11860);
    check_all("f1");

    // Outputs must hold the previous frame's value while the FSM is still working
    sof = 1'b1; tick(); sof = 1'b0; tick();
    check("f2 hold a.x", int'(if_a.topLeftX), 280);
    repeat (7) tick();
    m_frame();
    check("f2 a.x", int'(if_a.topLeftX), 281);
    check("f2 a.y", int'(if_a.topLeftY), 185);
    check("f2 a.ys", dut_a.y_speed, 22);
    check_all("f2");

    for (int f = 3; f <= 14; f++) begin
      run_frame();
      check_all($sformatf("f%0d", f));
      if (f == 13) begin
        check("sat b.x", int'(if_b.topLeftX), 608);
        check("sat b.xs", dut_b.x_speed, -40);
      end
      if (f == 14) check("unsat b.x", int'(if_b.topLeftX), 607);
    end

    // Right-edge hit: A moving right reverses, B already moving left stays
    pulse_hit(4'b0100);
    run_frame();
    check("bounce a.xs", dut_a.x_speed, -40);
    check("nostick b.xs", dut_b.x_speed, -40);
    check_all("bounce");
    pulse_hit(4'b0100);
    run_frame();
    check("nostick a.xs", dut_a.x_speed, -40);
    check_all("nostick");

    press_jump();
    run_frame();
    check("jump a.ys", dut_a.y_speed, -199);
    check_all("jump");
    for (int f = 0; f < 2; f++) begin
      run_frame();
      check_all($sformatf("hold jump %0d", f));
    end
    jk = 1'b0; tick();

    // Left hit landing exactly in the collide cycle must wait for the next frame
    sof = 1'b1; tick(); sof = 1'b0;
    col = 1'b1; code = 4'b0001; tick(); col = 1'b0; code = 4'b0;
    repeat (7) tick();
    m_frame();
    for (int i = 0; i < 2; i++) m_hits[i] |= 4'b0001;
    check("late hit a.xs", dut_a.x_speed, -40);
    check_all("late hit");
    run_frame();
    check("deferred hit a.xs", dut_a.x_speed, 40);
    check_all("deferred hit");

    for (int k = 0; k < 30; k++) begin
      int r;
      if ($urandom_range(0, 2) == 0) pulse_hit(4'($urandom_range(1, 15)));
      r = $urandom_range(0, 3);
      if (r == 0 && jk == 1'b0) press_jump();
      else if (r == 1) begin jk = 1'b0; tick(); end
      tick();
      run_frame();
      check_all($sformatf("rand %0d", k));
    end
    jk = 1'b0; tick();

    // Asynchronous reset in the middle of a frame
    sof = 1'b1; tick(); sof = 1'b0;
    @(posedge clk);
    #2 resetN = 1'b0;
    #1;
    check("mid reset a.x", int'(if_a.topLeftX), 280);
    check("mid reset a.y", int'(if_a.topLeftY), 185);
    check("mid reset state", int'(dut_a.state), int'(S_IDLE));
    m_reset();
    tick(); resetN = 1'b1; tick();
    run_frame();
    check("post reset a.posx", dut_a.pos_x, 17960);
    check_all("post reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
